// File: rtl/xc_sync_fifo_fwft_v2.sv
// Single-clock FIFO, FWFT or registered read, exact count and thresholds.
// Define XC_FIFO_STICKY_ERR_EN for sticky overflow/underflow flags.
module xc_sync_fifo_fwft_v2 #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int FWFT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  rd_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  ne_o,
  output logic [LOG2_DEPTH:0]   cnt_o,
  input  logic [LOG2_DEPTH:0]   af_thresh_i,
  input  logic [LOG2_DEPTH:0]   ae_thresh_i,
  output logic                  af_o,
  output logic                  ae_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [LOG2_DEPTH:0]   LP_DEPTH = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   LP_CONE  = (LOG2_DEPTH+1)'(1);
  localparam logic [LOG2_DEPTH-1:0] LP_PONE  = LOG2_DEPTH'(1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wp;
  logic [LOG2_DEPTH-1:0] r_rp;
  logic [LOG2_DEPTH:0]   r_cnt;

  logic w_full;
  logic w_ne;
  logic w_flush;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_cnt == LP_DEPTH);
  assign w_ne    = (r_cnt != '0);
  assign w_flush = rst_i | clr_i;
  assign w_wr    = wr_i & ~w_full & ~w_flush;
  assign w_rd    = rd_i & w_ne & ~w_flush;

  assign full_o = w_full;
  assign ne_o   = w_ne;
  assign cnt_o  = r_cnt;
  assign af_o   = (r_cnt >= af_thresh_i);
  assign ae_o   = (r_cnt <= ae_thresh_i);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wp] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + LP_PONE;
      if (w_rd) r_rp <= r_rp + LP_PONE;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + LP_CONE;
        2'b01:   r_cnt <= r_cnt - LP_CONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_o = r_mem[r_rp];
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk_i) begin
        if (w_flush)   r_dout <= '0;
        else if (w_rd) r_dout <= r_mem[r_rp];
      end
      assign data_o = r_dout;
    end
  endgenerate

`ifdef XC_FIFO_STICKY_ERR_EN
  logic r_ovf;
  logic r_udf;
  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr_i && w_full) r_ovf <= 1'b1;
      if (rd_i && !w_ne)  r_udf <= 1'b1;
    end
  end
  assign ovf_o = r_ovf;
  assign udf_o = r_udf;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_xc_sync_fifo_fwft_v2.sv
// Randomised bench for xc_sync_fifo_fwft_v2, FWFT and standard instances
// driven in parallel and compared against a queue model.
module tb_xc_sync_fifo_fwft_v2;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int LD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr;
  logic [W-1:0]  din;
  logic          rd;
  logic [LD:0]   af_th;
  logic [LD:0]   ae_th;

  logic [W-1:0]  f_dout, s_dout;
  logic          f_full, s_full, f_ne, s_ne;
  logic [LD:0]   f_cnt, s_cnt;
  logic          f_af, s_af, f_ae, s_ae;
  logic          f_ovf, s_ovf, f_udf, s_udf;

  always #5 clk = ~clk;

  xc_sync_fifo_fwft_v2 #(.WIDTH(W), .DEPTH(D), .LOG2_DEPTH(LD), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_i(wr), .data_i(din),
    .rd_i(rd), .data_o(f_dout), .full_o(f_full), .ne_o(f_ne),
    .cnt_o(f_cnt), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .af_o(f_af), .ae_o(f_ae), .ovf_o(f_ovf), .udf_o(f_udf)
  );

  xc_sync_fifo_fwft_v2 #(.WIDTH(W), .DEPTH(D), .LOG2_DEPTH(LD), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_i(wr), .data_i(din),
    .rd_i(rd), .data_o(s_dout), .full_o(s_full), .ne_o(s_ne),
    .cnt_o(s_cnt), .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .af_o(s_af), .ae_o(s_ae), .ovf_o(s_ovf), .udf_o(s_udf)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_std;
  logic         m_ovf;
  logic         m_udf;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    int n;
    logic eo, eu;
    n = q.size();
`ifdef XC_FIFO_STICKY_ERR_EN
    eo = m_ovf;
    eu = m_udf;
`else
    eo = 1'b0;
    eu = 1'b0;
`endif
    chk("f_cnt", 64'(f_cnt), 64'(n));
    chk("s_cnt", 64'(s_cnt), 64'(n));
    chk("f_full", 64'(f_full), 64'(n == D));
    chk("s_full", 64'(s_full), 64'(n == D));
    chk("f_ne", 64'(f_ne), 64'(n != 0));
    chk("s_ne", 64'(s_ne), 64'(n != 0));
    chk("f_af", 64'(f_af), 64'(n >= int'(af_th)));
    chk("s_af", 64'(s_af), 64'(n >= int'(af_th)));
    chk("f_ae", 64'(f_ae), 64'(n <= int'(ae_th)));
    chk("s_ae", 64'(s_ae), 64'(n <= int'(ae_th)));
    if (n != 0) chk("f_data", 64'(f_dout), 64'(q[0]));
    chk("s_data", 64'(s_dout), 64'(m_std));
    chk("f_ovf", 64'(f_ovf), 64'(eo));
    chk("s_ovf", 64'(s_ovf), 64'(eo));
    chk("f_udf", 64'(f_udf), 64'(eu));
    chk("s_udf", 64'(s_udf), 64'(eu));
  endtask

  // apply one cycle of stimulus, advance the model, then compare
  task automatic step(input logic w, input logic [W-1:0] d,
                      input logic r, input logic c);
    int  n;
    logic rok, wok;
    wr  = w;
    din = d;
    rd  = r;
    clr = c;
    @(posedge clk);
    n = q.size();
    if (rst || c) begin
      q.delete();
      m_std = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rok = r && (n > 0);
      wok = w && (n < D);
      if (w && n == D) m_ovf = 1'b1;
      if (r && n == 0) m_udf = 1'b1;
      if (rok) m_std = q.pop_front();
      if (wok) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] v;
    rst   = 1'b1;
    clr   = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;
    af_th = 4'd6;
    ae_th = 4'd1;
    m_std = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);

    for (int i = 0; i < 8; i++) step(1, W'(32'h100 + i), 0, 0);
    chk("fill_full", 64'(f_full), 64'd1);
    chk("fill_cnt", 64'(f_cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", 64'(f_dout), 64'(32'h100 + i));
      step(0, 0, 1, 0);
    end
    chk("drain_ne", 64'(f_ne), 64'd0);

    step(1, 32'hA5, 0, 0);
    chk("fwft_lat", 64'(f_dout), 64'hA5);
    step(0, 0, 1, 0);
    chk("std_lat", 64'(s_dout), 64'hA5);
    step(0, 0, 1, 0);
    chk("std_hold", 64'(s_dout), 64'hA5);

    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0);
    step(1, 32'hDEAD, 1, 0);
    chk("full_wr_rd", 64'(f_cnt), 64'd7);
    while (q.size() != 0) step(0, 0, 1, 0);
    step(1, 32'hBEEF, 1, 0);
    chk("empty_wr_rd", 64'(f_cnt), 64'd1);
    step(0, 0, 1, 0);

    for (int i = 0; i < 3; i++) step(1, W'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, W'(32'h2000 + i), 1, 0);
      chk("wrap_cnt", 64'(f_cnt), 64'd3);
    end
    step(1, W'($urandom), 0, 0);
    step(1, W'($urandom), 0, 0);
    chk("flush_pre", 64'(f_cnt), 64'd5);
    step(1, 32'h5555, 0, 1);
    chk("flush_cnt", 64'(f_cnt), 64'd0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, W'(i), 0, 0);
    step(1, 0, 0, 0);
    chk("flush_cnt5", 64'(f_cnt), 64'd8);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 32'h7777, 0, 1);
    chk("flush2_ne", 64'(f_ne), 64'd0);

    af_th = 4'd0;
    ae_th = 4'd8;
    step(0, 0, 0, 0);
    step(1, 32'h1, 0, 0);
    af_th = 4'd15;
    ae_th = 4'd15;
    step(0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      if (($urandom % 50) == 0) begin
        af_th = 4'($urandom_range(0, 10));
        ae_th = 4'($urandom_range(0, 10));
      end
      v = W'($urandom);
      step(1'($urandom), v, 1'($urandom), ($urandom % 64) == 0);
    end
    rst = 1'b1;
    step(1, 32'h9, 1, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xc_sync_fifo_fwft_v2.md
# xc_sync_fifo_fwft_v2

Parametrised single-clock FIFO with a selectable read mode: first-word-fall-through or standard one-cycle read latency. It carries its own storage and pointer logic instead of wrapping a core FIFO. It adds an exact occupancy count, full-width programmable almost-full/almost-empty thresholds, and optional sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain as the existing XC sync FIFOs.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 8, number of entries; must equal 2**LOG2_DEPTH
- LOG2_DEPTH, 3, pointer width
- FWFT, 1, 1 = first-word-fall-through read mode, 0 = standard mode
- clk_i  input  1  clock; all logic on the rising edge
- rst_i  input  1  reset, synchronous, active-high
- clr_i  input  1  synchronous flush; same effect as reset
- wr_i  input  1  write request
- data_i  input  WIDTH  write data
- rd_i  input  1  read/pop request
- data_o  output  WIDTH  read data
- full_o  output  1  count == DEPTH
- ne_o  output  1  count != 0
- cnt_o  output  LOG2_DEPTH+1  occupancy, 0..DEPTH
- af_thresh_i  input  LOG2_DEPTH+1  almost-full threshold
- ae_thresh_i  input  LOG2_DEPTH+1  almost-empty threshold
- af_o  output  1  cnt_o >= af_thresh_i
- ae_o  output  1  cnt_o <= ae_thresh_i
- ovf_o  output  1  sticky overflow (macro-dependent)
- udf_o  output  1  sticky underflow (macro-dependent)

## Operation
- Storage: DEPTH x WIDTH register array, no reset on the array. Write and read pointers are LOG2_DEPTH bits wide and wrap modulo DEPTH with no special case. Count register is LOG2_DEPTH+1 bits.
- Write acceptance: wr_i && !full_o, judged on the pre-edge state. On accept: mem[wp] <= data_i, wp increments.
- Read acceptance: rd_i && ne_o, judged on the pre-edge state. On accept: rp increments.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Full with wr_i and rd_i: read accepted, write rejected (overflow event). Count goes to DEPTH-1.
- Empty with wr_i and rd_i: write accepted, read rejected (underflow event). Count goes to 1.
- FWFT=1:
  - data_o = mem[rp], combinational from registered pointer and array.
  - data_o is valid whenever ne_o=1 and shows the head entry before rd_i.
  - When ne_o=0, data_o is don't-care.
- FWFT=0:
  - data_o is a register loaded with mem[rp] on an accepted read.
  - It holds its value otherwise, including across rejected reads.
- full_o, ne_o, af_o and ae_o are decoded from the count register and the threshold inputs. They carry no extra register stage.
- Threshold edge cases: af_thresh_i = 0 gives af_o = 1 always; ae_thresh_i >= DEPTH gives ae_o = 1 always.
- Reset or clr_i:
  - wp, rp and count go to 0; data_o register goes to 0.
  - Error flags go to 0.
  - Resulting outputs: full_o=0, ne_o=0, cnt_o=0, ovf_o=0, udf_o=0.
  - af_o and ae_o follow the thresholds at count 0.
- clr_i has priority over wr_i and rd_i in the same cycle; nothing is written or popped.

## Timing
- Write to ne_o: a write accepted at edge N raises ne_o and cnt_o after edge N.
- FWFT=1, empty FIFO: a write at edge N puts the data on data_o in cycle N+1; a pop is possible at edge N+1.
- FWFT=1, pop: a rd_i accepted at edge N shows the next entry on data_o in cycle N+1.
- FWFT=0: a rd_i accepted at edge N presents the popped word on data_o in cycle N+1 and holds it until the next accepted read.
- Throughput: one write and one read per cycle sustained, with no bubbles.
- Reset mid-stream: the next cycle looks empty, and all prior contents are lost.

## Configuration
- Macro XC_FIFO_STICKY_ERR_EN.
- Defined: ovf_o sets on any rejected write (wr_i && full_o) and udf_o sets on any rejected read (rd_i && !ne_o). Both stay set until rst_i or clr_i.
- Undefined: ovf_o and udf_o are tied to 0 and no flag registers exist. The rejection behaviour itself is unchanged.

## Test plan
- Fill then drain, WIDTH=32, DEPTH=8, FWFT=1:
  - Stimulus: write 0x100..0x107 on consecutive cycles.
  - full_o=1 and cnt_o=8 after the 8th edge.
  - Stimulus: rd_i held high.
  - data_o follows 0x100..0x107 one per cycle; ne_o=0 after the 8th pop.
- FWFT latency:
  - Stimulus: single write 0xA5 into an empty FIFO.
  - data_o=0xA5 and ne_o=1 in the next cycle.
  - Stimulus: same case with FWFT=0 and rd_i issued in that cycle.
  - data_o=0xA5 appears one cycle after the read and holds afterwards.
- Simultaneous events:
  - Stimulus: full FIFO with wr_i=rd_i=1.
  - cnt_o becomes 7 and ovf_o=1 (with macro).
  - Stimulus: empty FIFO with wr_i=rd_i=1.
  - cnt_o becomes 1 and udf_o=1 (with macro); with the macro undefined, ovf_o=udf_o=0.
- Wrap-around:
  - Stimulus: 20 interleaved write/read pairs at cnt_o=3.
  - Data order is preserved and cnt_o stays 3 throughout.
- Thresholds:
  - Stimulus: af_thresh_i=6, ae_thresh_i=1.
  - af_o rises exactly when cnt_o reaches 6.
  - ae_o=1 at counts 0 and 1, and 0 at count 2.
- Flush:
  - Stimulus: clr_i asserted together with wr_i at cnt_o=5, with sticky flags set.
  - Next cycle: cnt_o=0, ne_o=0, ovf_o=udf_o=0, and the concurrent write is discarded.
